// File: rtl/icache_direct_pkg.sv
// ============================================================================
// icache_direct_pkg : shared geometry defaults and FSM state encoding
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_direct_pkg;

    localparam int ICACHE_INDEX_WIDTH = 6;
    localparam int ICACHE_ADDR_WIDTH  = 18;
    localparam int ICACHE_WORD_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/icache_direct_if.sv
// ============================================================================
// icache_direct_if : fetch-side and RAM-side handshake bundle of the I-cache
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_direct_if;

    logic        invalidate;
    logic        if_read;
    logic [31:0] if_addr_i;
    logic        if_ready;
    logic [31:0] if_addr_o;
    logic [31:0] if_inst;
    logic        ram_busy;
    logic        ram_read;
    logic [31:0] ram_addr_o;
    logic        ram_ready;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_data_i;

    // slave is the cache itself; master is whatever drives fetches and RAM replies
    modport slave (
        input  invalidate, if_read, if_addr_i, ram_busy, ram_ready, ram_addr_i, ram_data_i,
        output if_ready, if_addr_o, if_inst, ram_read, ram_addr_o
    );

    modport master (
        output invalidate, if_read, if_addr_i, ram_busy, ram_ready, ram_addr_i, ram_data_i,
        input  if_ready, if_addr_o, if_inst, ram_read, ram_addr_o
    );

endinterface

`default_nettype wire

// File: rtl/icache_direct_array.sv
// ============================================================================
// icache_direct_array : tag/data/valid storage, async read, one write port
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_direct_array #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 10
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    input  wire logic [INDEX_WIDTH-1:0] rd_index,
    input  wire logic [TAG_WIDTH-1:0]   rd_tag,
    output logic                        rd_hit,
    output logic [31:0]                 rd_data,
    input  wire logic                   wr_en,
    input  wire logic [INDEX_WIDTH-1:0] wr_index,
    input  wire logic [TAG_WIDTH-1:0]   wr_tag,
    input  wire logic [31:0]            wr_data,
    input  wire logic                   inv_all
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [31:0]          data_q [LINES];
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     valid_d;

    // invalidate-all beats a coincident fill so the filled line stays invalid
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
        if (inv_all) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            data_q[wr_index] <= wr_data;
            tag_q[wr_index]  <= wr_tag;
        end
    end

    assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rd_data = data_q[rd_index];

endmodule

`default_nettype wire

// File: rtl/icache_direct.sv
// ============================================================================
// icache_direct : direct-mapped one-word-line instruction cache + miss FSM
// Optional ICACHE_STAT_EN adds hit_count / miss_count outputs.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH
) (
    input  wire logic      clock,
    input  wire logic      reset,
    icache_direct_if.slave bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]    hit_count,
    output logic [31:0]    miss_count
`endif
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

    state_e      state_q,      state_d;
    logic [31:0] miss_addr_q,  miss_addr_d;
    logic [31:0] last_addr_q,  last_addr_d;
    logic        served_q,     served_d;
    logic        if_ready_q,   if_ready_d;
    logic [31:0] if_addr_o_q,  if_addr_o_d;
    logic [31:0] if_inst_q,    if_inst_d;
    logic        ram_read_q,   ram_read_d;
    logic [31:0] ram_addr_o_q, ram_addr_o_d;

    logic        rd_hit;
    logic [31:0] rd_data;
    logic        fill_match;
    logic        req_new;
    logic        idle_hit;
    logic        idle_miss;

    icache_direct_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .rd_index (bus.if_addr_i[INDEX_WIDTH+1:2]),
        .rd_tag   (bus.if_addr_i[ADDR_WIDTH-1:INDEX_WIDTH+2]),
        .rd_hit   (rd_hit),
        .rd_data  (rd_data),
        .wr_en    (fill_match),
        .wr_index (miss_addr_q[INDEX_WIDTH+1:2]),
        .wr_tag   (miss_addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2]),
        .wr_data  (bus.ram_data_i),
        .inv_all  (bus.invalidate)
    );

    // A PC already answered is not served again until if_read drops or the PC moves
    assign req_new    = bus.if_read && !(served_q && (bus.if_addr_i == last_addr_q));
    assign idle_hit   = (state_q == IDLE) && req_new && rd_hit;
    assign idle_miss  = (state_q == IDLE) && req_new && !rd_hit;
    assign fill_match = (state_q == WAIT) && bus.ram_ready && (bus.ram_addr_i == miss_addr_q);

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        last_addr_d  = last_addr_q;
        served_d     = served_q && bus.if_read;
        if_ready_d   = 1'b0;
        if_addr_o_d  = if_addr_o_q;
        if_inst_d    = if_inst_q;
        ram_read_d   = 1'b0;
        ram_addr_o_d = ram_addr_o_q;
        case (state_q)
            IDLE: begin
                if (idle_hit) begin
                    if_ready_d  = 1'b1;
                    if_addr_o_d = bus.if_addr_i;
                    if_inst_d   = rd_data;
                    served_d    = 1'b1;
                    last_addr_d = bus.if_addr_i;
                end else if (idle_miss) begin
                    miss_addr_d = bus.if_addr_i;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (!bus.if_read) begin
                    state_d = IDLE;
                end else if (!bus.ram_busy) begin
                    ram_read_d   = 1'b1;
                    ram_addr_o_d = miss_addr_q;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                // fill always completes; a stale PC is dropped by stage_if's address compare
                if (fill_match) begin
                    if_ready_d  = 1'b1;
                    if_addr_o_d = miss_addr_q;
                    if_inst_d   = bus.ram_data_i;
                    served_d    = bus.if_read;
                    last_addr_d = miss_addr_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            last_addr_q  <= '0;
            served_q     <= 1'b0;
            if_ready_q   <= 1'b0;
            if_addr_o_q  <= '0;
            if_inst_q    <= '0;
            ram_read_q   <= 1'b0;
            ram_addr_o_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            last_addr_q  <= last_addr_d;
            served_q     <= served_d;
            if_ready_q   <= if_ready_d;
            if_addr_o_q  <= if_addr_o_d;
            if_inst_q    <= if_inst_d;
            ram_read_q   <= ram_read_d;
            ram_addr_o_q <= ram_addr_o_d;
        end
    end

    assign bus.if_ready   = if_ready_q;
    assign bus.if_addr_o  = if_addr_o_q;
    assign bus.if_inst    = if_inst_q;
    assign bus.ram_read   = ram_read_q;
    assign bus.ram_addr_o = ram_addr_o_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_count_q,  hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q  + {31'd0, idle_hit};
        miss_count_d = miss_count_q + {31'd0, idle_miss};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_direct.sv
// ============================================================================
// tb_icache_direct : directed + randomized self-checking bench for icache_direct
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_direct;

    logic clock = 1'b0;
    logic reset = 1'b0;

    icache_direct_if bus();

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    int          exp_hits   = 0;
    int          exp_misses = 0;
`endif

    icache_direct dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus)
`ifdef ICACHE_STAT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference: a 64-entry table of what the cache should hold
    bit          ref_valid [64];
    logic [9:0]  ref_tag   [64];
    logic [31:0] ref_data  [64];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[a[7:2]] && (ref_tag[a[7:2]] == a[17:8]);
    endfunction

    task automatic ref_invalidate();
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Deliver the matching RAM word (optionally with invalidate) and check the response
    task automatic fill_and_check(input logic [31:0] a, input bit inv);
        logic [31:0] d;
        d = mem_word(a);
        bus.ram_ready  = 1'b1;
        bus.ram_addr_i = a;
        bus.ram_data_i = d;
        bus.invalidate = inv;
        tick();
        bus.ram_ready  = 1'b0;
        bus.invalidate = 1'b0;
        check("fill_ready", 32'(bus.if_ready), 32'd1);
        check("fill_addr",  bus.if_addr_o, a);
        check("fill_inst",  bus.if_inst, d);
        if (inv) begin
            ref_invalidate();
        end else begin
            ref_valid[a[7:2]] = 1'b1;
            ref_tag[a[7:2]]   = a[17:8];
            ref_data[a[7:2]]  = d;
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input int busy, input bit junk,
                            input bit drop_wait, input bit inv_fill);
        bit hit;
        hit = ref_hit(a);
        bus.if_read   = 1'b1;
        bus.if_addr_i = a;
        tick();
        if (hit) begin
            check("hit_ready",  32'(bus.if_ready), 32'd1);
            check("hit_addr",   bus.if_addr_o, a);
            check("hit_inst",   bus.if_inst, ref_data[a[7:2]]);
            check("hit_no_ram", 32'(bus.ram_read), 32'd0);
`ifdef ICACHE_STAT_EN
            exp_hits++;
`endif
        end else begin
            check("miss_no_ready", 32'(bus.if_ready), 32'd0);
            bus.ram_busy = (busy > 0);
            for (int k = 0; k < busy; k++) begin
                tick();
                check("busy_no_read", 32'(bus.ram_read), 32'd0);
            end
            bus.ram_busy = 1'b0;
            tick();
            check("ram_read", 32'(bus.ram_read), 32'd1);
            check("ram_addr", bus.ram_addr_o, a);
            if (drop_wait) bus.if_read = 1'b0;
            tick();
            check("ram_read_pulse", 32'(bus.ram_read), 32'd0);
            if (junk) begin
                bus.ram_ready  = 1'b1;
                bus.ram_addr_i = a ^ 32'h4;
                bus.ram_data_i = $urandom;
                tick();
                bus.ram_ready  = 1'b0;
                check("junk_ignored", 32'(bus.if_ready), 32'd0);
            end
            repeat ($urandom_range(0, 2)) tick();
            fill_and_check(a, inv_fill);
`ifdef ICACHE_STAT_EN
            exp_misses++;
`endif
        end
        tick();
        check("single_pulse", 32'(bus.if_ready), 32'd0);
        bus.if_read = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] a;
        ref_invalidate();
        bus.invalidate = 1'b0;
        bus.if_read    = 1'b0;
        bus.if_addr_i  = '0;
        bus.ram_busy   = 1'b0;
        bus.ram_ready  = 1'b0;
        bus.ram_addr_i = '0;
        bus.ram_data_i = '0;
        repeat (3) tick();
        check("rst_if_ready",   32'(bus.if_ready), 32'd0);
        check("rst_if_addr_o",  bus.if_addr_o, 32'd0);
        check("rst_if_inst",    bus.if_inst, 32'd0);
        check("rst_ram_read",   32'(bus.ram_read), 32'd0);
        check("rst_ram_addr_o", bus.ram_addr_o, 32'd0);
        reset = 1'b1;
        tick();

        // first miss then hit, then alias eviction
        do_fetch(32'h100, 0, 1'b0, 1'b0, 1'b0);
        do_fetch(32'h100, 0, 1'b0, 1'b0, 1'b0);
        do_fetch(32'h200, 0, 1'b0, 1'b0, 1'b0);
        do_fetch(32'h100, 0, 1'b0, 1'b0, 1'b0);

        // RAM bus busy for 5 cycles in REQ
        do_fetch(32'h600, 5, 1'b1, 1'b0, 1'b0);

        // branch during WAIT: stale response still delivered, new PC served next
        bus.invalidate = 1'b1;
        tick();
        bus.invalidate = 1'b0;
        ref_invalidate();
        bus.if_read   = 1'b1;
        bus.if_addr_i = 32'h100;
        tick();
        tick();
        check("br_ram_read", 32'(bus.ram_read), 32'd1);
        check("br_ram_addr", bus.ram_addr_o, 32'h100);
        bus.if_addr_i = 32'h300;
        tick();
        fill_and_check(32'h100, 1'b0);
        tick();
        check("br_new_no_ready", 32'(bus.if_ready), 32'd0);
        tick();
        check("br_new_read", 32'(bus.ram_read), 32'd1);
        check("br_new_addr", bus.ram_addr_o, 32'h300);
        tick();
        fill_and_check(32'h300, 1'b0);
        bus.if_read = 1'b0;
        tick();
`ifdef ICACHE_STAT_EN
        exp_misses += 2;
`endif
        do_fetch(32'h100, 0, 1'b0, 1'b0, 1'b0);

        // invalidate coinciding with fill
        do_fetch(32'h104, 0, 1'b0, 1'b0, 1'b1);
        do_fetch(32'h104, 0, 1'b0, 1'b0, 1'b0);

        // if_read dropped in WAIT: fill still lands
        do_fetch(32'h700, 1, 1'b0, 1'b1, 1'b0);
        do_fetch(32'h700, 0, 1'b0, 1'b0, 1'b0);

        // if_read dropped in REQ: abort without a RAM read
        bus.ram_busy  = 1'b1;
        bus.if_read   = 1'b1;
        bus.if_addr_i = 32'h400;
        tick();
        tick();
        check("abort_busy_no_read", 32'(bus.ram_read), 32'd0);
        bus.if_read = 1'b0;
        tick();
        bus.ram_busy = 1'b0;
        tick();
        check("abort_no_read", 32'(bus.ram_read), 32'd0);
`ifdef ICACHE_STAT_EN
        exp_misses++;
`endif
        do_fetch(32'h400, 0, 1'b0, 1'b0, 1'b0);

        // back-to-back hits with the PC advancing every cycle
        do_fetch(32'h10, 0, 1'b0, 1'b0, 1'b0);
        do_fetch(32'h14, 0, 1'b0, 1'b0, 1'b0);
        bus.if_read   = 1'b1;
        bus.if_addr_i = 32'h10;
        tick();
        check("b2b_ready0", 32'(bus.if_ready), 32'd1);
        check("b2b_addr0",  bus.if_addr_o, 32'h10);
        bus.if_addr_i = 32'h14;
        tick();
        check("b2b_ready1", 32'(bus.if_ready), 32'd1);
        check("b2b_addr1",  bus.if_addr_o, 32'h14);
        check("b2b_inst1",  bus.if_inst, mem_word(32'h14));
        tick();
        check("b2b_hold", 32'(bus.if_ready), 32'd0);
        bus.if_read = 1'b0;
        tick();
`ifdef ICACHE_STAT_EN
        exp_hits += 2;
        check("stat_hits_mid",   hit_count,  32'(exp_hits));
        check("stat_misses_mid", miss_count, 32'(exp_misses));
`endif

        // reset in the middle of a miss
        bus.if_read   = 1'b1;
        bus.if_addr_i = 32'h500;
        tick();
        tick();
        check("rstmid_read", 32'(bus.ram_read), 32'd1);
        reset = 1'b0;
        #1;
        check("rstmid_async_read", 32'(bus.ram_read), 32'd0);
        check("rstmid_ram_addr",   bus.ram_addr_o, 32'd0);
        ref_invalidate();
`ifdef ICACHE_STAT_EN
        exp_hits   = 0;
        exp_misses = 0;
        check("rstmid_hits", hit_count, 32'd0);
`endif
        #2;
        reset       = 1'b1;
        bus.if_read = 1'b0;
        tick();
        bus.ram_ready  = 1'b1;
        bus.ram_addr_i = 32'h500;
        bus.ram_data_i = 32'hDEAD_BEEF;
        tick();
        bus.ram_ready = 1'b0;
        check("rstmid_no_resp", 32'(bus.if_ready), 32'd0);
        do_fetch(32'h500, 0, 1'b0, 1'b0, 1'b0);
        do_fetch(32'h10, 0, 1'b0, 1'b0, 1'b0);

        // randomized traffic over a small aliasing address pool
        for (int n = 0; n < 60; n++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 7) == 0) a[31:18] = 14'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                bus.invalidate = 1'b1;
                tick();
                bus.invalidate = 1'b0;
                ref_invalidate();
            end
            do_fetch(a, int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
        end

`ifdef ICACHE_STAT_EN
        check("stat_hits_end",   hit_count,  32'(exp_hits));
        check("stat_misses_end", miss_count, 32'(exp_misses));
        bus.invalidate = 1'b1;
        tick();
        bus.invalidate = 1'b0;
        tick();
        check("stat_hits_inv",   hit_count,  32'(exp_hits));
        check("stat_misses_inv", miss_count, 32'(exp_misses));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between stage_if and ctrl_mem.
- Serves instruction fetches on a hit without touching the byte-serial RAM bus.
- On a miss, issues one word read to ctrl_mem's IF port, fills the line and forwards the word.
- Frees the shared RAM bus for stage_mem on loop-heavy code.

Parameters:
- INDEX_WIDTH, 6, log2 of line count (64 lines of 32 bits).
- ADDR_WIDTH, 18, significant address bits (RAM plus I/O window); higher bits ignored.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- invalidate  input  1  one-cycle pulse; clears all valid bits (fence.i).
- if_read  input  1  fetch request from stage_if, level, held until if_ready.
- if_addr_i  input  32  fetch PC; bits [1:0] are always 0.
- if_ready  output  1  one-cycle pulse; if_inst is valid for if_addr_o.
- if_addr_o  output  32  PC that if_inst belongs to; stage_if discards a mismatch.
- if_inst  output  32  instruction word.
- ram_busy  input  1  ctrl_mem serving another request.
- ram_read  output  1  one-cycle word read request to ctrl_mem IF port.
- ram_addr_o  output  32  miss address.
- ram_ready  input  1  ctrl_mem word-complete pulse.
- ram_addr_i  input  32  address of the returned word.
- ram_data_i  input  32  returned word.

Behaviour:
- Address split:
  - offset = addr[1:0];
  - index = addr[INDEX_WIDTH+1:2];
  - tag = addr[ADDR_WIDTH-1:INDEX_WIDTH+2].
- Storage:
  - data and tag arrays are plain registers with no reset;
  - valid[] clears on reset or invalidate.
- Reset values: if_ready=0, if_addr_o=0, if_inst=0, ram_read=0, ram_addr_o=0, state=IDLE, all valid=0.
- States: IDLE, REQ, WAIT.
- IDLE:
  - if_read with hit → next cycle if_ready=1, if_addr_o=if_addr_i, if_inst=line data. Hit latency is 1 cycle.
  - if_read with miss → latch miss_addr=if_addr_i, go to REQ.
- REQ:
  - ram_busy=0 → ram_read=1 for one cycle with ram_addr_o=miss_addr, go to WAIT.
  - ram_busy=1 → hold in REQ with no request issued.
- WAIT: ram_ready && ram_addr_i==miss_addr →
  - write data/tag and set valid at index(miss_addr);
  - next cycle if_ready=1, if_addr_o=miss_addr, if_inst=ram_data_i;
  - return to IDLE.
- ram_ready with a non-matching ram_addr_i in WAIT: ignore it and keep waiting.
- PC change mid-miss (branch):
  - the miss in flight completes and fills anyway;
  - its response is still pulsed with if_addr_o=miss_addr, and stage_if drops it by address compare;
  - the new request is examined in IDLE on the following cycle.
- if_read dropped during REQ: abort to IDLE without issuing ram_read.
- if_read dropped during WAIT: the fill still completes.
- invalidate:
  - clears every valid bit in the same edge;
  - if it coincides with a fill, invalidate wins: line stays invalid, response is still delivered.
- Back-to-back hits: one response per cycle is permitted while if_read stays high and the PC changes.
  - if_ready must not pulse twice for the same unchanged if_addr_i without an intervening cycle of if_read=0 or a PC change.
- reset low mid-miss: state returns to IDLE immediately, ram_read deasserts asynchronously, no fill is written.

Optional Feature:
- ICACHE_STAT_EN defined:
  - adds outputs hit_count[31:0] and miss_count[31:0], counting IDLE hits and misses entered;
  - both reset to 0, wrap modulo 2^32, and are not cleared by invalidate.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared constants into define.v: ICacheIndexBus, ICacheTagBus, state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2).
- Reuse the existing MemAddrBus and InstBus definitions.
- One natural sub-module, icache_array: data/tag/valid storage with a combinational read port (hit, data) and a single write port plus invalidate-all.
- The FSM stays in icache_direct.

Test Plan:
- Reset, then if_read @0x00000100 → ram_read with ram_addr_o=0x100; return 0x00500093 → if_ready with if_inst=0x00500093. A second fetch @0x100 gives if_ready 1 cycle later with no ram_read.
- Alias check: fill 0x100, then fetch 0x200 (same index at INDEX_WIDTH=6, different tag) → miss and refill. Refetch 0x100 → miss again.
- ram_busy held high 5 cycles while in REQ → no ram_read until ram_busy falls; then exactly one ram_read.
- PC switches to 0x300 during WAIT for 0x100 → response carries if_addr_o=0x100. Next request 0x300 misses normally, and 0x100 is now a hit.
- invalidate in the same cycle as the fill of 0x104 → response delivered, but a later 0x104 fetch misses.
- ICACHE_STAT_EN: 3 hits plus 2 misses → hit_count=3, miss_count=2; invalidate leaves both unchanged.
